// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon input packer.
package ascon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_PUSH,
        ST_PAD,
        ST_DONE
    } pk_state_e;

    localparam logic [7:0] PadByte   = 8'h80;
    localparam int         RateBytes = 8;
    localparam int         WordBytes = 4;

endpackage

// File: rtl/ascon_blk_packer_if.sv
// Message-word, FIFO-push and control bundle between a source and the block packer.
interface ascon_blk_packer_if #(
    parameter int DataAddrWidth = 7,
    parameter int LenWidth      = 10
) ();

    logic                     start_i;
    logic                     clear_i;
    logic [LenWidth-1:0]      len_i;
    logic [31:0]              word_i;
    logic                     word_valid_i;
    logic                     word_ready_o;
    logic [63:0]              blk_o;
    logic                     push_o;
    logic                     full_i;
    logic [DataAddrWidth-1:0] nblk_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output start_i, clear_i, len_i, word_i, word_valid_i, full_i,
        input  word_ready_o, blk_o, push_o, nblk_o, busy_o, done_o
    );

    modport slave (
        input  start_i, clear_i, len_i, word_i, word_valid_i, full_i,
        output word_ready_o, blk_o, push_o, nblk_o, busy_o, done_o
    );

endinterface

// File: rtl/ascon_pad_mask.sv
// Keeps the first nb_i bytes of a big-endian word, zeroes the rest and
// drops the 0x80 pad byte right after the last kept byte when pad_i is set.
module ascon_pad_mask
    import ascon_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  nb_i,
    input  logic        pad_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        for (int k = 0; k < WordBytes; k++) begin
            if (3'(k) < nb_i) begin
                word_o[31-8*k -: 8] = word_i[31-8*k -: 8];
            end else if (pad_i && (3'(k) == nb_i)) begin
                word_o[31-8*k -: 8] = PadByte;
            end
        end
    end

endmodule

// File: rtl/ascon_blk_packer.sv
// Packs a byte-length message of 32-bit words into padded 64-bit rate blocks
// and pushes them into a FIFO; one word per cycle, stalls on full_i.
module ascon_blk_packer
    import ascon_pkg::*;
#(
    parameter int DataAddrWidth = 7,
    parameter int LenWidth      = 10,
    parameter bit EmptyNoBlock  = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    ascon_blk_packer_if.slave bus
);

    pk_state_e                state_q, state_d;
    logic [LenWidth-1:0]      rem_q, rem_d, rem_after;
    logic                     half_q, half_d;
    logic                     pad_done_q, pad_done_d;
    logic [63:0]              blk_q, blk_d;
    logic [DataAddrWidth-1:0] nblk_q, nblk_d;

    logic [2:0]  nb;
    logic [3:0]  used;
    logic        pad_now;
    logic        word_rdy;
    logic        word_fire;
    logic [31:0] word_masked;

    assign nb        = (rem_q >= LenWidth'(WordBytes)) ? 3'd4 : rem_q[2:0];
    assign rem_after = rem_q - LenWidth'(nb);
    assign used      = {1'b0, half_q, 2'b00} + {1'b0, nb};
    // Message ends inside this block: the pad byte still fits in it.
    assign pad_now   = (rem_after == '0) && (used < 4'(RateBytes));
    assign word_fire = bus.word_valid_i && word_rdy;

    ascon_pad_mask u_pad_mask (
        .word_i (bus.word_i),
        .nb_i   (nb),
        .pad_i  (pad_now),
        .word_o (word_masked)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        if (bus.len_i == '0) begin
                            state_d = EmptyNoBlock ? ST_DONE : ST_PAD;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (word_fire && (pad_now || half_q)) state_d = ST_PUSH;
                end
                ST_PUSH: begin
                    if (!bus.full_i) begin
                        if (pad_done_q)          state_d = ST_DONE;
                        else if (rem_q == '0)    state_d = ST_PAD;
                        else                     state_d = ST_COLLECT;
                    end
                end
                ST_PAD:  state_d = ST_PUSH;
                ST_DONE: begin
                    if (!bus.start_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        word_rdy         = (state_q == ST_COLLECT) && !bus.clear_i;
        bus.word_ready_o = word_rdy;
        bus.push_o       = (state_q == ST_PUSH) && !bus.full_i && !bus.clear_i;
        bus.busy_o       = (state_q != ST_IDLE);
        bus.done_o       = (state_q == ST_DONE);
        bus.blk_o        = blk_q;
        bus.nblk_o       = nblk_q;
    end

    always_comb begin
        rem_d      = rem_q;
        half_d     = half_q;
        pad_done_d = pad_done_q;
        blk_d      = blk_q;
        nblk_d     = nblk_q;
        if (!bus.clear_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        rem_d      = bus.len_i;
                        half_d     = 1'b0;
                        pad_done_d = 1'b0;
                        blk_d      = '0;
                        nblk_d     = (EmptyNoBlock && (bus.len_i == '0)) ? '0
                                   : DataAddrWidth'(bus.len_i >> 3) + 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (word_fire) begin
                        rem_d = rem_after;
                        if (half_q) begin
                            blk_d[31:0] = word_masked;
                        end else begin
                            blk_d[63:32] = word_masked;
                            // A full first word ending the message pushes the pad into the low half.
                            if (pad_now && (nb == 3'd4)) blk_d[31:0] = {PadByte, 24'h0};
                        end
                        if (pad_now)     pad_done_d = 1'b1;
                        else if (half_q) pad_done_d = 1'b0;
                        else             half_d     = 1'b1;
                    end
                end
                ST_PUSH: begin
                    if (!bus.full_i && !pad_done_q && (rem_q != '0)) begin
                        blk_d  = '0;
                        half_d = 1'b0;
                    end
                end
                ST_PAD: begin
                    blk_d      = {PadByte, 56'h0};
                    pad_done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_q      <= '0;
            half_q     <= 1'b0;
            pad_done_q <= 1'b0;
            blk_q      <= '0;
            nblk_q     <= '0;
        end else begin
            rem_q      <= rem_d;
            half_q     <= half_d;
            pad_done_q <= pad_done_d;
            blk_q      <= blk_d;
            nblk_q     <= nblk_d;
        end
    end

endmodule

// File: tb/tb_ascon_blk_packer.sv
// Drives one message stream into a PT-style and an AD-style packer and scoreboards the pushed blocks.
module tb_ascon_blk_packer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        wvld  = 1'b0;
    logic        full  = 1'b0;
    logic [9:0]  len   = '0;
    logic [31:0] word  = '0;

    always #5 clk = ~clk;

    ascon_blk_packer_if #(.DataAddrWidth(7), .LenWidth(10)) pt_if ();
    ascon_blk_packer_if #(.DataAddrWidth(7), .LenWidth(10)) ad_if ();

    assign pt_if.start_i      = start;
    assign pt_if.clear_i      = clear;
    assign pt_if.len_i        = len;
    assign pt_if.word_i       = word;
    assign pt_if.word_valid_i = wvld;
    assign pt_if.full_i       = full;
    assign ad_if.start_i      = start;
    assign ad_if.clear_i      = clear;
    assign ad_if.len_i        = len;
    assign ad_if.word_i       = word;
    assign ad_if.word_valid_i = wvld;
    assign ad_if.full_i       = full;

    ascon_blk_packer #(.DataAddrWidth(7), .LenWidth(10), .EmptyNoBlock(1'b0)) u_pt (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (pt_if.slave)
    );

    ascon_blk_packer #(.DataAddrWidth(7), .LenWidth(10), .EmptyNoBlock(1'b1)) u_ad (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (ad_if.slave)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] pt_q[$];
    logic [63:0] ad_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pt_if.push_o) begin
                if (pt_q.size() == 0) check_eq("pt_spurious_push", 64'(pt_q.size()), 64'd1);
                else                  check_eq("pt_blk", pt_if.blk_o, pt_q.pop_front());
            end
            if (ad_if.push_o) begin
                if (ad_q.size() == 0) check_eq("ad_spurious_push", 64'(ad_q.size()), 64'd1);
                else                  check_eq("ad_blk", ad_if.blk_o, ad_q.pop_front());
            end
        end
    end

    task automatic run_msg(input int mlen, input bit tog, input int stall);
        logic [31:0] words[$];
        logic [7:0]  pb[$];
        logic [31:0] w;
        logic [63:0] b;
        logic [63:0] first_blk;
        int          nw, idx, fires, stall_left, cyc, nb_exp;
        bit          seen_pt, seen_ad, fire;

        nw = (mlen + 3) / 4;
        for (int i = 0; i < nw; i++) words.push_back($urandom);
        for (int i = 0; i < mlen; i++) begin
            w = words[i/4];
            pb.push_back(w[31-8*(i%4) -: 8]);
        end
        pb.push_back(8'h80);
        while (pb.size() % 8 != 0) pb.push_back(8'h00);
        first_blk = '0;
        for (int k = 0; k < pb.size() / 8; k++) begin
            b = '0;
            for (int j = 0; j < 8; j++) b = {b[55:0], pb[8*k+j]};
            if (k == 0) first_blk = b;
            pt_q.push_back(b);
            if (mlen > 0) ad_q.push_back(b);
        end
        nb_exp = (mlen / 8 + 1) % 128;

        @(posedge clk); #1;
        start = 1'b1; len = 10'(mlen);
        stall_left = stall; full = (stall > 0);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; fires = 0; cyc = 0; seen_pt = 0; seen_ad = 0;
        wvld = 1'b1;
        word = (nw > 0) ? words[0] : 32'hDEAD_BEEF;
        for (int c = 0; c < 3000 && !(seen_pt && seen_ad); c++) begin
            @(negedge clk);
            fire = wvld && pt_if.word_ready_o;
            if (mlen == 0 && c == 0) check_eq("ad_empty_done", ad_if.done_o, 1'b1);
            if (pt_if.done_o) seen_pt = 1;
            if (ad_if.done_o) seen_ad = 1;
            if (stall_left > 0 && idx >= 2) begin
                check_eq("stall_push", pt_if.push_o, 1'b0);
                check_eq("stall_blk", pt_if.blk_o, first_blk);
                stall_left--;
            end
            @(posedge clk);
            if (fire) begin
                idx++;
                fires++;
            end
            #1;
            cyc++;
            full = (stall_left > 0);
            wvld = !tog || (cyc % 2 == 0);
            word = (idx < nw) ? words[idx] : 32'hDEAD_BEEF;
        end
        wvld = 1'b0;
        full = 1'b0;
        check_eq("done_seen", {seen_pt, seen_ad}, 2'b11);
        check_eq("words_taken", fires, nw);
        check_eq("pt_nblk", pt_if.nblk_o, nb_exp);
        check_eq("ad_nblk", ad_if.nblk_o, (mlen == 0) ? 0 : nb_exp);
        @(negedge clk);
        check_eq("busy_idle", {pt_if.busy_o, ad_if.busy_o}, 2'b00);
        check_eq("pt_q_left", pt_q.size(), 0);
        check_eq("ad_q_left", ad_q.size(), 0);
        pt_q.delete();
        ad_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},  {pt_if.busy_o, ad_if.busy_o}, 2'b00);
        check_eq({tag, "_ready"}, {pt_if.word_ready_o, ad_if.word_ready_o}, 2'b00);
        check_eq({tag, "_push"},  {pt_if.push_o, ad_if.push_o}, 2'b00);
        check_eq({tag, "_done"},  {pt_if.done_o, ad_if.done_o}, 2'b00);
    endtask

    initial begin
        @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset_blk", pt_if.blk_o, 64'h0);
        check_eq("reset_nblk", {pt_if.nblk_o, ad_if.nblk_o}, 14'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_msg(0, 1'b0, 0);
        run_msg(5, 1'b0, 0);
        run_msg(8, 1'b0, 0);
        run_msg(12, 1'b0, 5);
        run_msg(20, 1'b1, 0);

        // Abort with clear_i after one accepted word.
        @(posedge clk); #1;
        start = 1'b1; len = 10'd20;
        @(posedge clk); #1;
        start = 1'b0; wvld = 1'b1; word = 32'h0102_0304;
        @(posedge clk); #1;
        wvld = 1'b0; clear = 1'b1;
        @(negedge clk);
        check_eq("clear_push", pt_if.push_o, 1'b0);
        check_eq("clear_ready", pt_if.word_ready_o, 1'b0);
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check_idle_outputs("clear");
        check_eq("clear_nblk", pt_if.nblk_o, 7'd3);
        run_msg(4, 1'b0, 0);

        // Abort with reset after one accepted word.
        @(posedge clk); #1;
        start = 1'b1; len = 10'd20;
        @(posedge clk); #1;
        start = 1'b0; wvld = 1'b1; word = 32'hA1B2_C3D4;
        @(posedge clk); #1;
        wvld = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_rst");
        check_eq("mid_rst_blk", pt_if.blk_o, 64'h0);
        check_eq("mid_rst_nblk", pt_if.nblk_o, 7'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_msg(4, 1'b0, 0);

        for (int r = 0; r < 4; r++) run_msg($urandom_range(1, 40), 1'($urandom_range(0, 1)), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
